// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for mod_updown_counter.
// The master drives the control inputs; the counter (slave) drives count, tc and ovf.
interface mod_updown_counter_if #(
    parameter int WIDTH = 8
);
    logic             sclr;
    logic             ld;
    logic [WIDTH-1:0] d_in;
    logic             en;
    logic             up;
    logic             sat;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    modport master (output sclr, ld, d_in, en, up, sat, input  count, tc, ovf);
    modport slave  (input  sclr, ld, d_in, en, up, sat, output count, tc, ovf);
endinterface

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with a DIV-cycle enable prescaler, load clamp,
// wrap/saturate boundary mode, combinational terminal count and a sticky overflow flag.
module mod_updown_counter #(
    parameter int     WIDTH = 8,
    parameter longint MOD   = 200,
    parameter int     DIV   = 1
) (
    input  logic                clk,
    input  logic                clr_n,
    mod_updown_counter_if.slave bus
);
    localparam int               PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH:0]   MOD_X    = (WIDTH+1)'(MOD);
    localparam logic [WIDTH:0]   TOP_X    = (WIDTH+1)'(MOD - 1);
    localparam logic [WIDTH-1:0] TOP      = WIDTH'(MOD - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pre_q, pre_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH:0]   inc_x;
    logic             at_top;
    logic             at_zero;
    logic             boundary;
    logic             pre_wrap;
    logic             step;

    // The increment carries into bit WIDTH so MOD = 2^WIDTH is detected without overflow.
    always_comb begin
        inc_x    = {1'b0, count_q} + (WIDTH+1)'(1);
        at_top   = (inc_x == MOD_X);
        at_zero  = (count_q == '0);
        boundary = bus.up ? at_top : at_zero;
        pre_wrap = (pre_q == PRE_LAST);
        step     = bus.en & pre_wrap & ~bus.sclr & ~bus.ld;
    end

    assign bus.tc    = step & boundary;
    assign bus.count = count_q;
    assign bus.ovf   = ovf_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        count_d = count_q;
        pre_d   = pre_q;
        ovf_d   = ovf_q;
        if (bus.sclr) begin
            count_d = '0;
            pre_d   = '0;
            ovf_d   = 1'b0;
        end else if (bus.ld) begin
            count_d = ({1'b0, bus.d_in} > TOP_X) ? TOP : bus.d_in;
            pre_d   = '0;
        end else if (bus.en) begin
            pre_d = pre_wrap ? '0 : pre_q + PW'(1);
            if (step) begin
                if (boundary) begin
                    ovf_d = 1'b1;
                    if (!bus.sat) begin
                        count_d = bus.up ? '0 : TOP;
                    end
                end else begin
                    count_d = bus.up ? inc_x[WIDTH-1:0] : count_q - WIDTH'(1);
                end
            end
        end
    end

    // NOTE: registers use non-blocking assignments so all of them sample pre-edge values.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_q <= '0;
            pre_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: three configurations share one stimulus stream;
// expected count/ovf go through a scoreboard queue, tc is checked before each edge.
module tb_mod_updown_counter;
    logic clk = 1'b0;
    logic clr_n;
    always #5 clk = ~clk;

    logic       s_sclr, s_ld, s_en, s_up, s_sat;
    logic [7:0] s_d;

    mod_updown_counter_if #(.WIDTH(8)) ifa ();
    mod_updown_counter_if #(.WIDTH(8)) ifb ();
    mod_updown_counter_if #(.WIDTH(4)) ifc ();

    assign ifa.sclr = s_sclr; assign ifa.ld = s_ld; assign ifa.d_in = s_d;
    assign ifa.en   = s_en;   assign ifa.up = s_up; assign ifa.sat  = s_sat;
    assign ifb.sclr = s_sclr; assign ifb.ld = s_ld; assign ifb.d_in = s_d;
    assign ifb.en   = s_en;   assign ifb.up = s_up; assign ifb.sat  = s_sat;
    assign ifc.sclr = s_sclr; assign ifc.ld = s_ld; assign ifc.d_in = s_d[3:0];
    assign ifc.en   = s_en;   assign ifc.up = s_up; assign ifc.sat  = s_sat;

    mod_updown_counter #(.WIDTH(8), .MOD(200), .DIV(1)) dut_a (.clk(clk), .clr_n(clr_n), .bus(ifa.slave));
    mod_updown_counter #(.WIDTH(8), .MOD(10),  .DIV(4)) dut_b (.clk(clk), .clr_n(clr_n), .bus(ifb.slave));
    mod_updown_counter #(.WIDTH(4), .MOD(16),  .DIV(1)) dut_c (.clk(clk), .clr_n(clr_n), .bus(ifc.slave));

    int          sel = 0;
    logic [31:0] obs_count;
    logic        obs_tc, obs_ovf;

    always_comb begin
        obs_count = 32'(ifa.count);
        obs_tc    = ifa.tc;
        obs_ovf   = ifa.ovf;
        if (sel == 1) begin
            obs_count = 32'(ifb.count);
            obs_tc    = ifb.tc;
            obs_ovf   = ifb.ovf;
        end else if (sel == 2) begin
            obs_count = 32'(ifc.count);
            obs_tc    = ifc.tc;
            obs_ovf   = ifc.ovf;
        end
    end

    typedef struct {
        logic        sc, l;
        logic [7:0]  d;
        logic        e, u, s;
        logic        xtc;
        logic [31:0] xcnt;
        logic        xovf;
    } vec_t;

    typedef struct {
        logic [31:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    logic tc_seen;

    function automatic vec_t mk(input int sc, l, d, e, u, s, xtc, xcnt, xovf);
        vec_t v;
        v.sc = sc[0]; v.l = l[0]; v.d = d[7:0];
        v.e  = e[0];  v.u = u[0]; v.s = s[0];
        v.xtc = xtc[0]; v.xcnt = 32'(xcnt); v.xovf = xovf[0];
        return v;
    endfunction

    // Applies one cycle of inputs, captures tc before the edge, then waits past the edge.
    task automatic tick(input vec_t v);
        s_sclr = v.sc; s_ld = v.l; s_d = v.d;
        s_en   = v.e;  s_up = v.u; s_sat = v.s;
        #1;
        tc_seen = obs_tc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        sel = 0;
        total++;
        if (obs_count !== 32'd0 || obs_ovf !== 1'b0)
            $display("FAIL reset_state count=%0d ovf=%b expected count=0 ovf=0", obs_count, obs_ovf);
        else passed++;
        clr_n = 1'b1;
        sb.push_back('{32'd37, 1'b0});
        tick(mk(0, 1, 37, 0, 1, 0, 0, 37, 0));
        e = sb.pop_front();
        total++;
        if (obs_count !== e.cnt || obs_ovf !== e.ovf)
            $display("FAIL reset_preload count=%0d ovf=%b expected count=%0d ovf=%b", obs_count, obs_ovf, e.cnt, e.ovf);
        else passed++;
        s_ld = 1'b0;
        #3 clr_n = 1'b0;
        #1;
        total++;
        if (obs_count !== 32'd0 || obs_ovf !== 1'b0)
            $display("FAIL reset_async count=%0d ovf=%b expected count=0 ovf=0", obs_count, obs_ovf);
        else passed++;
        #2 clr_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            sb.push_back('{32'(i), 1'b0});
            tick(mk(0, 0, 0, 1, 1, 0, 0, i, 0));
            e = sb.pop_front();
            total++;
            if (obs_count !== e.cnt || obs_ovf !== e.ovf)
                $display("FAIL reset_release[%0d] count=%0d ovf=%b expected count=%0d ovf=%b", i, obs_count, obs_ovf, e.cnt, e.ovf);
            else passed++;
        end
    endtask

    task automatic test_up_wrap();
        vec_t v[$];
        exp_t e;
        sel = 0;
        v.push_back(mk(1, 0, 0,   0, 1, 0, 0, 0,   0));
        v.push_back(mk(0, 1, 198, 0, 1, 0, 0, 198, 0));
        v.push_back(mk(0, 0, 0,   1, 1, 0, 0, 199, 0));
        v.push_back(mk(0, 0, 0,   1, 1, 0, 1, 0,   1));
        for (int i = 0; i < 10; i++) v.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
        v.push_back(mk(1, 0, 0,   0, 1, 0, 0, 0,   0));
        foreach (v[i]) begin
            sb.push_back('{v[i].xcnt, v[i].xovf});
            tick(v[i]);
            total++;
            if (tc_seen !== v[i].xtc) $display("FAIL up_wrap_tc[%0d] tc=%b expected %b", i, tc_seen, v[i].xtc);
            else passed++;
            e = sb.pop_front();
            total++;
            if (obs_count !== e.cnt || obs_ovf !== e.ovf)
                $display("FAIL up_wrap[%0d] count=%0d ovf=%b expected count=%0d ovf=%b", i, obs_count, obs_ovf, e.cnt, e.ovf);
            else passed++;
        end
    endtask

    task automatic test_down_sat();
        vec_t v[$];
        exp_t e;
        sel = 0;
        v.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0));
        v.push_back(mk(0, 1, 1, 0, 0, 1, 0, 1, 0));
        v.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0));
        for (int i = 0; i < 5; i++) v.push_back(mk(0, 0, 0, 1, 0, 1, 1, 0, 1));
        foreach (v[i]) begin
            sb.push_back('{v[i].xcnt, v[i].xovf});
            tick(v[i]);
            total++;
            if (tc_seen !== v[i].xtc) $display("FAIL down_sat_tc[%0d] tc=%b expected %b", i, tc_seen, v[i].xtc);
            else passed++;
            e = sb.pop_front();
            total++;
            if (obs_count !== e.cnt || obs_ovf !== e.ovf)
                $display("FAIL down_sat[%0d] count=%0d ovf=%b expected count=%0d ovf=%b", i, obs_count, obs_ovf, e.cnt, e.ovf);
            else passed++;
        end
    endtask

    // Entered with ovf already set, so the first load also shows ld leaves ovf alone.
    task automatic test_load_priority();
        vec_t v[$];
        exp_t e;
        sel = 0;
        v.push_back(mk(0, 1, 250, 0, 1, 0, 0, 199, 1));
        v.push_back(mk(1, 1, 77,  1, 1, 0, 0, 0,   0));
        v.push_back(mk(0, 1, 5,   1, 1, 0, 0, 5,   0));
        v.push_back(mk(0, 1, 200, 0, 1, 0, 0, 199, 0));
        v.push_back(mk(0, 1, 199, 1, 1, 0, 0, 199, 0));
        v.push_back(mk(0, 0, 0,   1, 1, 0, 1, 0,   1));
        foreach (v[i]) begin
            sb.push_back('{v[i].xcnt, v[i].xovf});
            tick(v[i]);
            total++;
            if (tc_seen !== v[i].xtc) $display("FAIL load_prio_tc[%0d] tc=%b expected %b", i, tc_seen, v[i].xtc);
            else passed++;
            e = sb.pop_front();
            total++;
            if (obs_count !== e.cnt || obs_ovf !== e.ovf)
                $display("FAIL load_prio[%0d] count=%0d ovf=%b expected count=%0d ovf=%b", i, obs_count, obs_ovf, e.cnt, e.ovf);
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        vec_t v[$];
        exp_t e;
        sel = 0;
        v.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0,   0));
        v.push_back(mk(0, 0, 0, 1, 1, 0, 0, 1,   0));
        v.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,   0));
        v.push_back(mk(0, 0, 0, 1, 0, 0, 1, 199, 1));
        v.push_back(mk(0, 0, 0, 1, 1, 1, 1, 199, 1));
        v.push_back(mk(0, 0, 0, 1, 0, 1, 0, 198, 1));
        foreach (v[i]) begin
            sb.push_back('{v[i].xcnt, v[i].xovf});
            tick(v[i]);
            total++;
            if (tc_seen !== v[i].xtc) $display("FAIL b2b_tc[%0d] tc=%b expected %b", i, tc_seen, v[i].xtc);
            else passed++;
            e = sb.pop_front();
            total++;
            if (obs_count !== e.cnt || obs_ovf !== e.ovf)
                $display("FAIL b2b[%0d] count=%0d ovf=%b expected count=%0d ovf=%b", i, obs_count, obs_ovf, e.cnt, e.ovf);
            else passed++;
        end
    endtask

    // DIV = 4, MOD = 10: a step lands on every 4th enabled edge after a clear.
    task automatic test_prescaler();
        vec_t v[$];
        exp_t e;
        int   en_pat[6]  = '{1, 1, 0, 0, 1, 1};
        int   cnt_pat[6] = '{0, 0, 0, 0, 0, 1};
        sel = 1;
        v.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int k = 1; k <= 40; k++)
            v.push_back(mk(0, 0, 0, 1, 1, 0, int'((k % 4 == 0) && (k == 40)), (k / 4) % 10, int'(k >= 40)));
        for (int k = 0; k < 6; k++)
            v.push_back(mk(0, 0, 0, en_pat[k], 1, 0, 0, cnt_pat[k], 1));
        foreach (v[i]) begin
            sb.push_back('{v[i].xcnt, v[i].xovf});
            tick(v[i]);
            total++;
            if (tc_seen !== v[i].xtc) $display("FAIL presc_tc[%0d] tc=%b expected %b", i, tc_seen, v[i].xtc);
            else passed++;
            e = sb.pop_front();
            total++;
            if (obs_count !== e.cnt || obs_ovf !== e.ovf)
                $display("FAIL presc[%0d] count=%0d ovf=%b expected count=%0d ovf=%b", i, obs_count, obs_ovf, e.cnt, e.ovf);
            else passed++;
        end
    endtask

    // WIDTH = 4, MOD = 16: the modulus equals 2^WIDTH.
    task automatic test_full_range();
        vec_t v[$];
        exp_t e;
        sel = 2;
        v.push_back(mk(1, 0, 0,  0, 1, 0, 0, 0,  0));
        v.push_back(mk(0, 1, 15, 0, 1, 0, 0, 15, 0));
        v.push_back(mk(0, 0, 0,  1, 1, 0, 1, 0,  1));
        v.push_back(mk(1, 0, 0,  0, 0, 0, 0, 0,  0));
        v.push_back(mk(0, 0, 0,  1, 0, 0, 1, 15, 1));
        v.push_back(mk(0, 0, 0,  1, 1, 1, 1, 15, 1));
        v.push_back(mk(0, 0, 0,  1, 1, 0, 1, 0,  1));
        foreach (v[i]) begin
            sb.push_back('{v[i].xcnt, v[i].xovf});
            tick(v[i]);
            total++;
            if (tc_seen !== v[i].xtc) $display("FAIL full_tc[%0d] tc=%b expected %b", i, tc_seen, v[i].xtc);
            else passed++;
            e = sb.pop_front();
            total++;
            if (obs_count !== e.cnt || obs_ovf !== e.ovf)
                $display("FAIL full[%0d] count=%0d ovf=%b expected count=%0d ovf=%b", i, obs_count, obs_ovf, e.cnt, e.ovf);
            else passed++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

    initial begin
        clr_n  = 1'b0;
        s_sclr = 1'b0; s_ld = 1'b0; s_d = 8'd0;
        s_en   = 1'b0; s_up = 1'b0; s_sat = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_up_wrap();
        test_down_sat();
        test_load_priority();
        test_back_to_back();
        test_prescaler();
        test_full_range();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
